sram_io_host: RTL and testbench



---
 rtl/sram_io_host.sv | 167 ++++++++++++++++
 tb/tb_sram_io_host.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_io_host.sv
// sram_io_host: host-side sequencer for the SRAM serial I/O controller.
// Turns parallel read/write commands into LOAD_N/CTRL/SI operations.
module sram_io_host #(
    parameter int MEMORY_DATA_WIDTH = 8,
    parameter int MEMORY_ADDR_WIDTH = 9,
    parameter int WDOG_LIMIT        = 8
) (
    input  logic                         CLK,
    input  logic                         BGN,
    input  logic                         CMD_VLD,
    output logic                         CMD_RDY,
    input  logic                         CMD_WR,
    input  logic [MEMORY_ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [MEMORY_DATA_WIDTH-1:0] CMD_WDATA,
    output logic                         DONE,
    output logic                         ERR,
    output logic [MEMORY_DATA_WIDTH-1:0] RDATA,
    output logic                         LOAD_N,
    output logic [1:0]                   CTRL,
    output logic                         SI,
    input  logic                         RDY,
    input  logic                         SO
);

    localparam int D   = MEMORY_DATA_WIDTH;
    localparam int A   = MEMORY_ADDR_WIDTH;
    localparam int N   = A + D;
    localparam int OPW = $clog2(2 * N);
    localparam int WDW = $clog2(WDOG_LIMIT + 1);

    // op index of the memory op, and of the last read tail shift
    localparam logic [OPW-1:0] OP_MEM     = OPW'(N);
    localparam logic [OPW-1:0] OP_LAST_RD = OPW'(N + D - 1);
    localparam logic [WDW-1:0] WD_LAST    = WDW'(WDOG_LIMIT - 1);

    localparam logic [1:0] C_SHIFT = 2'b00;
    localparam logic [1:0] C_WRITE = 2'b11;
    localparam logic [1:0] C_READ  = 2'b01;

    typedef enum logic [2:0] {
        H_IDLE,
        H_PULSE,
        H_GUARD,
        H_WAIT,
        H_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [N-1:0]     word_q;
    logic             wr_q;
    logic [OPW-1:0]   op_q;
    logic [OPW-1:0]   op_nxt;
    logic [D-1:0]     rdata_q;
    logic [WDW-1:0]   wdog_q;
    logic [1:0]       ctrl_q;
    logic             si_q;
    logic             err_q;
    logic             accept;
    logic             op_end;
    logic             wd_trip;
    logic             last_op;
    logic             capture;

    assign accept  = (state == H_IDLE) && CMD_VLD;
    assign op_end  = (state == H_WAIT) && RDY;
    assign wd_trip = (state == H_WAIT) && !RDY && (wdog_q == WD_LAST);
    assign last_op = wr_q ? (op_q == OP_MEM) : (op_q == OP_LAST_RD);
    assign capture = !wr_q && (op_q >= OP_MEM);
    assign op_nxt  = op_q + 1'b1;

    // phase register
    always_ff @(posedge CLK) begin
        if (!BGN) state <= H_IDLE;
        else      state <= state_nxt;
    end

    // phase sequencing: pulse, guard, wait per operation
    always_comb begin
        state_nxt = state;
        unique case (state)
            H_IDLE:  if (accept) state_nxt = H_PULSE;
            H_PULSE: state_nxt = H_GUARD;
            H_GUARD: state_nxt = H_WAIT;
            H_WAIT: begin
                if (op_end)       state_nxt = last_op ? H_DONE : H_PULSE;
                else if (wd_trip) state_nxt = H_DONE;
            end
            H_DONE:  state_nxt = H_IDLE;
            default: state_nxt = H_IDLE;
        endcase
    end

    // phase-decoded strobes
    always_comb begin
        LOAD_N  = 1'b1;
        DONE    = 1'b0;
        CMD_RDY = 1'b0;
        unique case (state)
            H_IDLE:  CMD_RDY = 1'b1;
            H_PULSE: LOAD_N  = 1'b0;
            H_DONE:  DONE    = 1'b1;
            default: ;
        endcase
    end

    // command word, op counter, CTRL/SI, capture and watchdog
    always_ff @(posedge CLK) begin
        if (!BGN) begin
            word_q  <= '0;
            wr_q    <= 1'b0;
            op_q    <= '0;
            rdata_q <= '0;
            wdog_q  <= '0;
            ctrl_q  <= C_SHIFT;
            si_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                word_q  <= CMD_WR ? {CMD_ADDR, CMD_WDATA}
                                  : {CMD_ADDR, {D{1'b0}}};
                wr_q    <= CMD_WR;
                op_q    <= '0;
                rdata_q <= '0;
                err_q   <= 1'b0;
                ctrl_q  <= C_SHIFT;
                si_q    <= CMD_WR & CMD_WDATA[0];
            end
            if (state == H_PULSE) wdog_q <= '0;
            if (state == H_WAIT) begin
                if (RDY) begin
                    op_q   <= op_nxt;
                    wdog_q <= '0;
                    word_q <= word_q >> 1;
                    if (capture) rdata_q <= {SO, rdata_q[D-1:1]};
                    if (last_op) begin
                        ctrl_q <= C_SHIFT;
                        si_q   <= 1'b0;
                    end else if (op_nxt < OP_MEM) begin
                        ctrl_q <= C_SHIFT;
                        si_q   <= word_q[1];
                    end else if (op_nxt == OP_MEM) begin
                        ctrl_q <= wr_q ? C_WRITE : C_READ;
                        si_q   <= 1'b0;
                    end else begin
                        ctrl_q <= C_SHIFT;
                        si_q   <= 1'b0;
                    end
                end else begin
                    wdog_q <= wdog_q + 1'b1;
                    if (wd_trip) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        ctrl_q  <= C_SHIFT;
                        si_q    <= 1'b0;
                    end
                end
            end
        end
    end

    assign CTRL  = ctrl_q;
    assign SI    = si_q;
    assign ERR   = err_q;
    assign RDATA = rdata_q;

endmodule

// File: tb/tb_sram_io_host.sv
// tb_sram_io_host: directed bench with a controller+SRAM model and
// a schedule model of the expected operation stream.
module tb_sram_io_host;

    logic       CLK = 1'b0;
    logic       BGN = 1'b0;
    logic       CMD_VLD = 1'b0;
    logic       CMD_WR = 1'b0;
    logic [8:0] CMD_ADDR = '0;
    logic [7:0] CMD_WDATA = '0;
    logic       CMD_RDY;
    logic       DONE;
    logic       ERR;
    logic [7:0] RDATA;
    logic       LOAD_N;
    logic [1:0] CTRL;
    logic       SI;
    logic       RDY;
    logic       SO;

    int n_chk = 0;
    int n_fail = 0;
    bit stall = 1'b0;

    always #5 CLK = ~CLK;

    sram_io_host #(
        .MEMORY_DATA_WIDTH(8),
        .MEMORY_ADDR_WIDTH(9),
        .WDOG_LIMIT(8)
    ) dut (
        .CLK(CLK),
        .BGN(BGN),
        .CMD_VLD(CMD_VLD),
        .CMD_RDY(CMD_RDY),
        .CMD_WR(CMD_WR),
        .CMD_ADDR(CMD_ADDR),
        .CMD_WDATA(CMD_WDATA),
        .DONE(DONE),
        .ERR(ERR),
        .RDATA(RDATA),
        .LOAD_N(LOAD_N),
        .CTRL(CTRL),
        .SI(SI),
        .RDY(RDY),
        .SO(SO)
    );

    // controller + SRAM model
    logic [16:0] sr = '0;
    bit          busy_c = 1'b0;
    int          age = 0;
    logic [1:0]  op_c = '0;
    bit   [7:0]  mem [512];
    bit   [7:0]  exp_mem [512];

    always @(posedge CLK) begin
        if (!BGN) begin
            busy_c <= 1'b0;
            age    <= 0;
            sr     <= '0;
        end else if (!busy_c) begin
            if (!LOAD_N) begin
                busy_c <= 1'b1;
                age    <= 0;
            end
        end else begin
            age <= age + 1;
            if (age == 1) op_c <= CTRL;
            if (age == 2) begin
                case (op_c)
                    2'b00: sr <= {SI, sr[16:1]};
                    2'b11: mem[sr[16:8]] <= sr[7:0];
                    2'b01: sr[7:0] <= mem[sr[16:8]];
                    default: ;
                endcase
            end
            if (age == ((op_c == 2'b01) ? 4 : 3)) busy_c <= 1'b0;
        end
    end

    assign RDY = stall ? 1'b0
               : (!busy_c || age == 0 || age >= ((op_c == 2'b01) ? 4 : 3));
    assign SO  = sr[0];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Issue one command (called at a negedge in idle) and check every
    // cycle against the expected operation schedule.
    task automatic run_cmd(input bit wr, input logic [8:0] a,
                           input logic [7:0] d, input bit hold,
                           input bit nwr, input logic [8:0] na,
                           input logic [7:0] nd, input int abort_at,
                           output int done_cyc, output int pulses,
                           output logic [7:0] rd);
        int         lens[$];
        logic [1:0] ctls[$];
        bit         sis[$];
        bit         sichk[$];
        logic [16:0] w;
        int         exp_done;
        int         j;
        int         st;
        bit         in_op;
        logic [7:0] exp_rd;

        w = {a, wr ? d : 8'h00};
        for (int i = 0; i < 17; i++) begin
            lens.push_back(5); ctls.push_back(2'b00);
            sis.push_back(w[i]); sichk.push_back(1'b1);
        end
        lens.push_back(wr ? 5 : 6);
        ctls.push_back(wr ? 2'b11 : 2'b01);
        sis.push_back(1'b0); sichk.push_back(1'b0);
        if (!wr) begin
            for (int k = 1; k < 8; k++) begin
                lens.push_back(5); ctls.push_back(2'b00);
                sis.push_back(1'b0); sichk.push_back(1'b1);
            end
        end
        exp_done = 1;
        foreach (lens[i]) exp_done += lens[i];
        exp_rd = wr ? 8'h00 : exp_mem[a];

        CMD_VLD = 1'b1; CMD_WR = wr; CMD_ADDR = a; CMD_WDATA = d;
        chk("cmd_rdy_idle", CMD_RDY, 1);
        @(posedge CLK);
        @(negedge CLK);
        if (hold) begin
            CMD_WR = nwr; CMD_ADDR = na; CMD_WDATA = nd;
        end else begin
            CMD_VLD = 1'b0;
        end

        done_cyc = -1; pulses = 0; rd = '0;
        j = 0; st = 1;
        for (int c = 1; c <= exp_done + 3; c++) begin
            while (j < lens.size() && c >= st + lens[j]) begin
                st += lens[j];
                j++;
            end
            in_op = (j < lens.size());
            chk("load_n", LOAD_N, (in_op && c == st) ? 0 : 1);
            if (in_op) begin
                chk("ctrl", CTRL, ctls[j]);
                if (sichk[j]) chk("si", SI, sis[j]);
            end
            chk("cmd_rdy_busy", CMD_RDY, 0);
            chk("done", DONE, (c == exp_done) ? 1 : 0);
            if (!LOAD_N) pulses++;
            if (DONE) begin
                done_cyc = c;
                rd = RDATA;
                chk("err", ERR, 0);
                chk("rdata", RDATA, exp_rd);
                break;
            end
            if (c == abort_at) begin
                BGN = 1'b0;
                @(posedge CLK);
                @(negedge CLK);
                chk("rst_load_n", LOAD_N, 1);
                chk("rst_ctrl", CTRL, 0);
                chk("rst_si", SI, 0);
                chk("rst_cmd_rdy", CMD_RDY, 1);
                chk("rst_done", DONE, 0);
                BGN = 1'b1;
                repeat (12) begin
                    @(negedge CLK);
                    chk("no_done_after_rst", DONE, 0);
                    chk("no_pulse_after_rst", LOAD_N, 1);
                end
                done_cyc = -1;
                return;
            end
            @(negedge CLK);
        end
        chk("done_cycle_model", done_cyc, exp_done);
        if (wr) exp_mem[a] = d;
        @(negedge CLK);
        chk("cmd_rdy_after", CMD_RDY, 1);
        chk("done_after", DONE, 0);
        chk("load_n_after", LOAD_N, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int         dc;
        int         p;
        logic [7:0] rd;

        BGN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_load_n", LOAD_N, 1);
        chk("reset_ctrl", CTRL, 0);
        chk("reset_si", SI, 0);
        chk("reset_done", DONE, 0);
        chk("reset_err", ERR, 0);
        chk("reset_rdata", RDATA, 0);
        chk("reset_cmd_rdy", CMD_RDY, 1);
        BGN = 1'b1;
        @(negedge CLK);

        run_cmd(1, 9'h1A5, 8'h3C, 0, 0, '0, '0, 0, dc, p, rd);
        chk("wr_latency", dc, 91);
        chk("wr_pulses", p, 18);
        chk("wr_rdata_zero", rd, 8'h00);

        run_cmd(0, 9'h1A5, 8'h00, 0, 0, '0, '0, 0, dc, p, rd);
        chk("rd_latency", dc, 127);
        chk("rd_pulses", p, 25);
        chk("rd_data_1a5", rd, 8'h3C);

        run_cmd(1, 9'h000, 8'hA5, 0, 0, '0, '0, 0, dc, p, rd);
        run_cmd(0, 9'h000, 8'h00, 0, 0, '0, '0, 0, dc, p, rd);
        chk("rd_data_000", rd, 8'hA5);

        run_cmd(1, 9'h001, 8'h01, 0, 0, '0, '0, 0, dc, p, rd);
        run_cmd(0, 9'h001, 8'h00, 0, 0, '0, '0, 0, dc, p, rd);
        chk("rd_bit0", rd, 8'h01);

        run_cmd(1, 9'h002, 8'h80, 0, 0, '0, '0, 0, dc, p, rd);
        run_cmd(0, 9'h002, 8'h00, 0, 0, '0, '0, 0, dc, p, rd);
        chk("rd_bit7", rd, 8'h80);

        // busy: a read is held valid throughout a write
        run_cmd(1, 9'h010, 8'h5A, 1, 0, 9'h010, 8'h00, 0, dc, p, rd);
        chk("busy_wr_latency", dc, 91);
        chk("busy_wr_pulses", p, 18);
        run_cmd(0, 9'h010, 8'h00, 0, 0, '0, '0, 0, dc, p, rd);
        chk("busy_rd_data", rd, 8'h5A);

        // reset in the middle of a write, then a clean write/read
        run_cmd(1, 9'h0F0, 8'hEE, 0, 0, '0, '0, 40, dc, p, rd);
        run_cmd(1, 9'h0F0, 8'h11, 0, 0, '0, '0, 0, dc, p, rd);
        chk("post_rst_wr_latency", dc, 91);
        run_cmd(0, 9'h0F0, 8'h00, 0, 0, '0, '0, 0, dc, p, rd);
        chk("post_rst_rd_data", rd, 8'h11);

        // watchdog: RDY held low after the first pulse
        CMD_VLD = 1'b1; CMD_WR = 1'b1; CMD_ADDR = 9'h055; CMD_WDATA = 8'h77;
        @(posedge CLK);
        @(negedge CLK);
        CMD_VLD = 1'b0;
        stall = 1'b1;
        chk("wd_first_pulse", LOAD_N, 0);
        for (int c = 2; c <= 12; c++) begin
            @(negedge CLK);
            chk("wd_load_n", LOAD_N, 1);
            if (c < 11) begin
                chk("wd_no_done", DONE, 0);
                chk("wd_busy", CMD_RDY, 0);
            end else if (c == 11) begin
                chk("wd_done", DONE, 1);
                chk("wd_err", ERR, 1);
                chk("wd_rdata", RDATA, 0);
            end else begin
                chk("wd_cmd_rdy", CMD_RDY, 1);
                chk("wd_done_clear", DONE, 0);
            end
        end
        repeat (10) begin
            @(negedge CLK);
            chk("wd_no_more_pulses", LOAD_N, 1);
        end
        stall = 1'b0;
        @(negedge CLK);

        run_cmd(0, 9'h1A5, 8'h00, 0, 0, '0, '0, 0, dc, p, rd);
        chk("final_rd_data", rd, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
